// File: rtl/pmem_types_pkg.sv
// Purpose: shared line/beat geometry and responder state encoding for the pmem path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pmem_types_pkg;

  // Line width on the cache side and beat width on the memory side.
  localparam int S_LINE = 256;
  localparam int S_BEAT = 64;

  // BEATS must be a power of two so the beat counter wraps cleanly.
  localparam int BEATS  = S_LINE / S_BEAT;
  localparam int CNT_W  = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } pmem_state_t;

endpackage

// File: rtl/pmem_burst_responder_line_beat_buffer.sv
// Purpose: one-line staging register, loaded whole or one beat at a time, read one beat at a time.
// Latency: writes visible the cycle after the edge; the beat read port is combinational.
// Backpressure: none; the owner decides when to load or write.
// Ports:
//   clk, rst               clock, synchronous active-high reset (clears the line)
//   load_en, load_line     parallel load of a full line (takes priority over beat_we)
//   beat_we, beat_in       write beat_in into slot beat_idx
//   beat_idx               slot select for both the beat write and the beat read
//   beat_out, line_out     selected beat and the whole stored line
module line_beat_buffer
  import pmem_types_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [S_LINE-1:0] load_line,
  input  logic              beat_we,
  input  logic [CNT_W-1:0]  beat_idx,
  input  logic [S_BEAT-1:0] beat_in,
  output logic [S_BEAT-1:0] beat_out,
  output logic [S_LINE-1:0] line_out
);

  logic [S_LINE-1:0] line_q;
  logic [S_LINE-1:0] line_d;

  always_comb begin
    line_d = line_q;
    if (load_en) begin
      line_d = load_line;
    end else if (beat_we) begin
      line_d[beat_idx*S_BEAT +: S_BEAT] = beat_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign beat_out = line_q[beat_idx*S_BEAT +: S_BEAT];
  assign line_out = line_q;

endmodule

// File: rtl/pmem_burst_responder.sv
// Purpose: turns one cache line read/write into a BEATS-beat burst to physical memory.
// Latency: request edge N -> first burst cycle N+1 -> pmem_resp one cycle after the last beat (min N+5).
// Backpressure: burst_resp low stalls the beat counter indefinitely; one request in flight at a time.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   pmem_read/pmem_write          cache line requests, held until pmem_resp
//   pmem_address, pmem_wdata      line address (low 5 bits ignored), write line
//   pmem_rdata, pmem_resp         assembled read line, one-cycle completion pulse
//   burst_read/burst_write        burst requests to memory, high for the whole burst
//   burst_address, burst_wdata    line-aligned address, current write beat
//   burst_rdata, burst_resp       read beat, per-beat accept/valid strobe
module pmem_burst_responder
  import pmem_types_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [31:0]       pmem_address,
  input  logic [S_LINE-1:0] pmem_wdata,
  output logic [S_LINE-1:0] pmem_rdata,
  output logic              pmem_resp,
  output logic              burst_read,
  output logic              burst_write,
  output logic [31:0]       burst_address,
  output logic [S_BEAT-1:0] burst_wdata,
  input  logic [S_BEAT-1:0] burst_rdata,
  input  logic              burst_resp
);

  pmem_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [26:0]       addr_q, addr_d;
  logic [S_LINE-1:0] rdata_q, rdata_d;

  logic              buf_load;
  logic              buf_we;
  logic [S_BEAT-1:0] buf_beat;
  logic [S_LINE-1:0] buf_line;
  logic              last_beat;

  // Offset bits within the line are deliberately dropped.
  logic unused_addr_lo;
  assign unused_addr_lo = ^pmem_address[4:0];

  assign last_beat = burst_resp && (cnt_q == CNT_W'(BEATS - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rdata_d     = rdata_q;
    buf_load    = 1'b0;
    buf_we      = 1'b0;
    burst_read  = 1'b0;
    burst_write = 1'b0;
    pmem_resp   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Write first so a dirty victim is written back before the fill.
        if (pmem_write) begin
          addr_d   = pmem_address[31:5];
          buf_load = 1'b1;
          state_d  = WR_BURST;
        end else if (pmem_read) begin
          addr_d  = pmem_address[31:5];
          state_d = RD_BURST;
        end
      end
      RD_BURST: begin
        burst_read = 1'b1;
        if (burst_resp) begin
          buf_we = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
        end
        if (last_beat) begin
          // Beats arrive in slot order, so the final beat is always the top
          // slot; merge it here so the line is complete in the DONE cycle.
          rdata_d = {burst_rdata, buf_line[S_LINE-S_BEAT-1:0]};
          state_d = DONE;
        end
      end
      WR_BURST: begin
        burst_write = 1'b1;
        if (burst_resp) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (last_beat) begin
          state_d = DONE;
        end
      end
      DONE: begin
        pmem_resp = 1'b1;
        cnt_d     = '0;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
    end
  end

  line_beat_buffer u_buf (
    .clk       (clk),
    .rst       (rst),
    .load_en   (buf_load),
    .load_line (pmem_wdata),
    .beat_we   (buf_we),
    .beat_idx  (cnt_q),
    .beat_in   (burst_rdata),
    .beat_out  (buf_beat),
    .line_out  (buf_line)
  );

  // pmem_rdata comes from its own register so it holds the last read line
  // through later write bursts and through the next read's gather.
  assign pmem_rdata    = rdata_q;
  assign burst_address = {addr_q, 5'b0};
  assign burst_wdata   = (state_q == WR_BURST) ? buf_beat : '0;

endmodule

// File: tb/tb_pmem_burst_responder.sv
module tb_pmem_burst_responder;
  import pmem_types_pkg::*;

  logic              clk;
  logic              rst;
  logic              pmem_read;
  logic              pmem_write;
  logic [31:0]       pmem_address;
  logic [S_LINE-1:0] pmem_wdata;
  logic [S_LINE-1:0] pmem_rdata;
  logic              pmem_resp;
  logic              burst_read;
  logic              burst_write;
  logic [31:0]       burst_address;
  logic [S_BEAT-1:0] burst_wdata;
  logic [S_BEAT-1:0] burst_rdata;
  logic              burst_resp;

  int checks   = 0;
  int failures = 0;
  logic [255:0] last_line;

  pmem_burst_responder dut (
    .clk           (clk),
    .rst           (rst),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_address  (pmem_address),
    .pmem_wdata    (pmem_wdata),
    .pmem_rdata    (pmem_rdata),
    .pmem_resp     (pmem_resp),
    .burst_read    (burst_read),
    .burst_write   (burst_write),
    .burst_address (burst_address),
    .burst_wdata   (burst_wdata),
    .burst_rdata   (burst_rdata),
    .burst_resp    (burst_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         is_write;
    logic [31:0]  addr;
    logic [255:0] line;
    logic [15:0]  resp_mask;  // bit c-1 set: memory responds in burst cycle c
    logic [31:0]  exp_addr;
    int           exp_lat;    // cycles from request edge to the pmem_resp cycle
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Called at a negedge while the responder is idle. Drives one line
  // request, plays the memory side, and checks every cycle until the
  // completion pulse plus one idle cycle afterwards.
  task automatic run_txn(input logic wr, input logic rd_too, input logic hold_rd,
                         input logic [31:0] addr, input logic [31:0] exp_addr,
                         input logic [255:0] line, input logic [15:0] mask,
                         input logic use_mask, input int exp_lat);
    int   beats;
    int   cyc;
    logic done;
    logic give;
    pmem_write   = wr;
    pmem_read    = !wr || rd_too;
    pmem_address = addr;
    pmem_wdata   = wr ? line : rand256();
    beats = 0;
    cyc   = 0;
    done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      burst_resp  = 1'b0;
      burst_rdata = rand64();
      if (beats < 4) begin
        chk("burst_read", burst_read, !wr);
        chk("burst_write", burst_write, wr);
        chk("burst_address", burst_address, exp_addr);
        chk("pmem_resp_early", pmem_resp, 1'b0);
        chk("pmem_rdata_hold", pmem_rdata, last_line);
        if (wr) chk("burst_wdata", burst_wdata, line[beats*64 +: 64]);
        if (use_mask) give = (cyc <= 16) && mask[cyc-1];
        else          give = ($urandom_range(0, 2) != 0);
        if (give) begin
          burst_resp = 1'b1;
          if (!wr) burst_rdata = line[beats*64 +: 64];
          beats++;
        end
        if (cyc > 60) begin
          checks++;
          failures++;
          $display("FAIL burst_timeout actual=%0d beats expected=4", beats);
          pmem_write = 1'b0;
          pmem_read  = 1'b0;
          done = 1'b1;
        end
      end else begin
        chk("pmem_resp", pmem_resp, 1'b1);
        chk("burst_read_done", burst_read, 1'b0);
        chk("burst_write_done", burst_write, 1'b0);
        if (!wr) begin
          last_line = line;
          chk("pmem_rdata", pmem_rdata, line);
        end
        if (exp_lat > 0) chk("latency", cyc, exp_lat);
        // A stray strobe outside the burst must be ignored.
        burst_resp = 1'($urandom_range(0, 1));
        pmem_write = 1'b0;
        if (!hold_rd) pmem_read = 1'b0;
        done = 1'b1;
      end
    end
    @(negedge clk);
    chk("pmem_resp_single", pmem_resp, 1'b0);
    chk("burst_read_idle", burst_read, 1'b0);
    chk("burst_write_idle", burst_write, 1'b0);
    chk("pmem_rdata_idle", pmem_rdata, last_line);
    burst_resp = 1'($urandom_range(0, 1));
  endtask

  initial begin
    logic [31:0]  a;
    logic [255:0] l;
    logic         w;

    vecs[0] = '{1'b0, 32'h0000_1234,
                {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002,
                 64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000},
                16'h000F, 32'h0000_1220, 5};
    vecs[1] = '{1'b1, 32'h8000_0040,
                {64'hD3D3_1111_2222_3333, 64'hD2D2_4444_5555_6666,
                 64'hD1D1_7777_8888_9999, 64'hD0D0_AAAA_BBBB_CCCC},
                16'h000F, 32'h8000_0040, 5};
    vecs[2] = '{1'b0, 32'hDEAD_BEEF,
                {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                 64'h5555_AAAA_5555_AAAA, 64'hC0FF_EE00_1234_5678},
                16'h0132, 32'hDEAD_BEE0, 10};
    vecs[3] = '{1'b1, 32'h0000_001F,
                {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444},
                16'h004D, 32'h0000_0000, 8};

    rst          = 1'b1;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    burst_rdata  = '0;
    burst_resp   = 1'b0;
    last_line    = '0;
    repeat (2) @(negedge clk);
    chk("rst_pmem_resp", pmem_resp, 1'b0);
    chk("rst_burst_read", burst_read, 1'b0);
    chk("rst_burst_write", burst_write, 1'b0);
    chk("rst_burst_address", burst_address, 32'h0);
    chk("rst_burst_wdata", burst_wdata, 64'h0);
    chk("rst_pmem_rdata", pmem_rdata, 256'h0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table.
    foreach (vecs[i]) begin
      run_txn(vecs[i].is_write, 1'b0, 1'b0, vecs[i].addr, vecs[i].exp_addr,
              vecs[i].line, vecs[i].resp_mask, 1'b1, vecs[i].exp_lat);
    end

    // Stray burst_resp while idle: nothing moves.
    for (int i = 0; i < 3; i++) begin
      burst_resp  = 1'b1;
      burst_rdata = rand64();
      @(negedge clk);
      chk("stray_pmem_resp", pmem_resp, 1'b0);
      chk("stray_burst_read", burst_read, 1'b0);
      chk("stray_burst_write", burst_write, 1'b0);
      chk("stray_pmem_rdata", pmem_rdata, last_line);
    end
    burst_resp = 1'b0;
    run_txn(1'b0, 1'b0, 1'b0, 32'h0000_3000, 32'h0000_3000, rand256(), 16'h000F, 1'b1, 5);

    // Read and write together: the write is served first, then the read.
    run_txn(1'b1, 1'b1, 1'b1, 32'h1000_0080, 32'h1000_0080, rand256(), 16'h000F, 1'b1, 5);
    run_txn(1'b0, 1'b0, 1'b0, 32'h1000_0080, 32'h1000_0080, rand256(), 16'h00AA, 1'b1, 9);

    // Reset after two read beats: burst aborted, no completion, line cleared.
    l = rand256();
    pmem_read    = 1'b1;
    pmem_address = 32'h4000_0104;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      chk("abort_burst_read", burst_read, 1'b1);
      burst_resp  = 1'b1;
      burst_rdata = l[b*64 +: 64];
    end
    @(negedge clk);
    chk("abort_pre_rst_read", burst_read, 1'b1);
    burst_resp = 1'b0;
    pmem_read  = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    chk("abort_burst_read_off", burst_read, 1'b0);
    chk("abort_no_resp", pmem_resp, 1'b0);
    chk("abort_rdata_cleared", pmem_rdata, 256'h0);
    rst       = 1'b0;
    last_line = '0;
    repeat (3) begin
      @(negedge clk);
      chk("post_abort_no_resp", pmem_resp, 1'b0);
      chk("post_abort_idle", burst_read, 1'b0);
    end
    run_txn(1'b0, 1'b0, 1'b0, 32'h4000_0104, 32'h4000_0100, rand256(), 16'h000F, 1'b1, 5);

    // Randomized traffic with random memory stalls.
    for (int t = 0; t < 30; t++) begin
      w = 1'($urandom_range(0, 1));
      a = $urandom;
      l = rand256();
      run_txn(w, 1'b0, 1'b0, a, {a[31:5], 5'b0}, l, 16'h0, 1'b0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
